// File: rtl/demux_1x4_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : demux_1x4_router                                              |
// | Brief    : Buffered 1-to-4 demultiplexer, addressed or round-robin,     |
// |            one-entry valid/ready holding register per output channel.   |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module demux_1x4_router #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             mode,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr
);

    localparam logic [3:0] c_one_hot = 4'b0001;

    logic [WIDTH-1:0] r_data [4];
    logic [3:0]       r_valid;
    logic [1:0]       r_ptr;

    logic [1:0] w_target;
    logic       w_accept;
    logic [3:0] w_fill;
    logic [3:0] w_drain;

    // in_ready depends only on the target slot, never on in_valid
    assign w_target = mode ? r_ptr : sel;
    assign in_ready = ~r_valid[w_target] | out_ready[w_target];
    assign w_accept = in_valid & in_ready;
    assign w_fill   = w_accept ? (c_one_hot << w_target) : 4'b0000;
    assign w_drain  = r_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 4'b0000;
            r_ptr   <= 2'b00;
        end else begin
            // a fill wins over a drain of the same slot, so there is no bubble
            r_valid <= (r_valid & ~w_drain) | w_fill;
            if (mode && w_accept) begin
                r_ptr <= r_ptr + 2'd1;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_chan
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data[k] <= '0;
            end else if (w_fill[k]) begin
                r_data[k] <= in_data;
            end
        end
    end

    assign out_a     = r_data[0];
    assign out_b     = r_data[1];
    assign out_c     = r_data[2];
    assign out_d     = r_data[3];
    assign out_valid = r_valid;
    assign rr_ptr    = r_ptr;

endmodule
`default_nettype wire
